// File: rtl/transpose_rd_fsm_mh.sv
// transpose_rd_fsm_mh
// Multi-head read sequencer for a TIN-wide transpose buffer. A job is
// launched by a start pulse, which latches pixel_in / pixel_out / head_num.
// The job then walks the buffer in TOUT-row tiles, emitting one read beat per
// valid/ready handshake. A saturating credit counter tracks free downstream
// slots; no beat is offered without a credit.
// Optional build macro: TRANSPOSE_STALL_CNT_EN adds a 32-bit stall_cnt output
// counting RUN cycles in which no beat fires.
module transpose_rd_fsm_mh #(
  parameter int TIN        = 64,
  parameter int TOUT       = 16,
  parameter int PIX_W      = 12,
  parameter int HEAD_W     = 4,
  parameter int CREDIT_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PIX_W-1:0]         pixel_in,
  input  logic [PIX_W-1:0]         pixel_out,
  input  logic [HEAD_W-1:0]        head_num,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [$clog2(TIN)-1:0]   rd_addr,
  output logic [$clog2(TIN):0]     rd_addr_max,
  output logic                     rd_last,
  input  logic                     credit_vld
`ifdef TRANSPOSE_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int AW  = $clog2(TIN);
  localparam int TW  = $clog2(TOUT);
  localparam int R   = TIN / TOUT;
  localparam int RW  = (R > 1) ? $clog2(R) : 1;
  localparam int CW  = $clog2(CREDIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [PIX_W-1:0]    pix_in_r;
  logic [PIX_W-1:0]    pix_out_r;
  logic [HEAD_W-1:0]   head_num_r;

  logic [RW-1:0]       blk_in_r;
  logic [TW-1:0]       blk_out_r;
  logic [PIX_W-1:0]    chin_r;
  logic [PIX_W-1:0]    chout_r;
  logic [HEAD_W-1:0]   head_r;
  logic [CW-1:0]       credit_r;

  logic                run_s;
  logic                start_acc_s;
  logic                cfg_zero_s;
  logic                fire_s;
  logic [PIX_W-1:0]    pix_in_m1_s;
  logic [PIX_W-1:0]    pix_out_m1_s;
  logic [PIX_W-1:0]    chin_max_s;
  logic [PIX_W-1:0]    chout_max_s;
  logic [TW:0]         rem_s;
  logic                last_tile_s;
  logic [TW-1:0]       len_m1_s;
  logic                blk_in_wrap_s;
  logic                blk_out_wrap_s;
  logic                chin_wrap_s;
  logic                head_wrap_s;
  logic                last_s;
  logic [AW-1:0]       addr_s;
  logic [AW:0]         addr_max_s;

  // Tile geometry is derived from the latched configuration. Counts use the
  // (x-1)>>log2 form so the maximum pixel count never overflows PIX_W bits.
  assign pix_in_m1_s  = pix_in_r - PIX_W'(1'b1);
  assign pix_out_m1_s = pix_out_r - PIX_W'(1'b1);
  assign chin_max_s   = pix_out_m1_s >> AW;
  assign chout_max_s  = pix_in_m1_s >> TW;
  assign rem_s        = {1'b0, pix_in_m1_s[TW-1:0]} + (TW+1)'(1'b1);
  assign last_tile_s  = (chout_r == chout_max_s);
  assign len_m1_s     = last_tile_s ? pix_in_m1_s[TW-1:0] : {TW{1'b1}};

  assign blk_in_wrap_s  = (blk_in_r == RW'(R - 1));
  assign blk_out_wrap_s = (blk_out_r == len_m1_s);
  assign chin_wrap_s    = (chin_r == chin_max_s);
  assign head_wrap_s    = (head_r == (head_num_r - HEAD_W'(1'b1)));
  assign last_s         = blk_in_wrap_s && blk_out_wrap_s && chin_wrap_s &&
                          last_tile_s && head_wrap_s;

  assign run_s       = (state_r == RUN);
  assign start_acc_s = (state_r == IDLE) && start;
  assign cfg_zero_s  = (pixel_in == {PIX_W{1'b0}}) || (pixel_out == {PIX_W{1'b0}}) ||
                       (head_num == {HEAD_W{1'b0}});

  assign rd_vld = run_s && (credit_r != {CW{1'b0}});
  assign fire_s = rd_vld && rd_rdy;
  assign busy   = (state_r != IDLE);
  assign done   = (state_r == DONE);

  assign addr_s     = (AW'(blk_out_r) * AW'(R)) + AW'(blk_in_r);
  assign addr_max_s = last_tile_s ? ((AW+1)'(rem_s) * (AW+1)'(R)) : (AW+1)'(TIN);

  // Beat outputs come straight from counter registers and are held at zero
  // outside RUN so that reset and idle present an all-zero interface.
  always_comb begin
    rd_addr     = {AW{1'b0}};
    rd_addr_max = {(AW+1){1'b0}};
    rd_last     = 1'b0;
    if (run_s) begin
      rd_addr     = addr_s;
      rd_addr_max = addr_max_s;
      rd_last     = last_s;
    end else begin
      rd_addr     = {AW{1'b0}};
      rd_addr_max = {(AW+1){1'b0}};
      rd_last     = 1'b0;
    end
  end

  // Next-state logic: a zero-sized job skips RUN and only produces done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = cfg_zero_s ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (fire_s && last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; reset aborts any job without passing through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Per-job configuration latched only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_in_r   <= {PIX_W{1'b0}};
      pix_out_r  <= {PIX_W{1'b0}};
      head_num_r <= {HEAD_W{1'b0}};
    end else if (start_acc_s) begin
      pix_in_r   <= pixel_in;
      pix_out_r  <= pixel_out;
      head_num_r <= head_num;
    end else begin
      pix_in_r   <= pix_in_r;
      pix_out_r  <= pix_out_r;
      head_num_r <= head_num_r;
    end
  end

  // Nested beat counters, innermost blk_in; each advances when all inner
  // counters wrap on a firing beat. The final beat wraps everything to zero.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      blk_in_r  <= {RW{1'b0}};
      blk_out_r <= {TW{1'b0}};
      chin_r    <= {PIX_W{1'b0}};
      chout_r   <= {PIX_W{1'b0}};
      head_r    <= {HEAD_W{1'b0}};
    end else if (fire_s) begin
      if (blk_in_wrap_s) begin
        blk_in_r <= {RW{1'b0}};
        if (blk_out_wrap_s) begin
          blk_out_r <= {TW{1'b0}};
          if (chin_wrap_s) begin
            chin_r <= {PIX_W{1'b0}};
            if (last_tile_s) begin
              chout_r <= {PIX_W{1'b0}};
              if (head_wrap_s) begin
                head_r <= {HEAD_W{1'b0}};
              end else begin
                head_r <= head_r + HEAD_W'(1'b1);
              end
            end else begin
              chout_r <= chout_r + PIX_W'(1'b1);
            end
          end else begin
            chin_r <= chin_r + PIX_W'(1'b1);
          end
        end else begin
          blk_out_r <= blk_out_r + TW'(1'b1);
        end
      end else begin
        blk_in_r <= blk_in_r + RW'(1'b1);
      end
    end else begin
      blk_in_r  <= blk_in_r;
      blk_out_r <= blk_out_r;
      chin_r    <= chin_r;
      chout_r   <= chout_r;
      head_r    <= head_r;
    end
  end

  // Downstream credits: beat consumes, credit_vld returns (saturating);
  // credits survive across jobs and are only reinitialised by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= CW'(CREDIT_MAX);
    end else begin
      case ({fire_s, credit_vld})
        2'b10: credit_r <= credit_r - CW'(1'b1);
        2'b01: begin
          if (credit_r != CW'(CREDIT_MAX)) begin
            credit_r <= credit_r + CW'(1'b1);
          end else begin
            credit_r <= credit_r;
          end
        end
        default: credit_r <= credit_r;
      endcase
    end
  end

`ifdef TRANSPOSE_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Count RUN cycles without a firing beat, saturating; cleared per job.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      stall_cnt_r <= 32'd0;
    end else if (run_s && !fire_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_transpose_rd_fsm_mh.sv
// Self-checking bench for transpose_rd_fsm_mh (TIN=64, TOUT=16).
// Expected beats are generated by a reference loop nest into a scoreboard
// queue when a job is launched and are popped as beats fire.
module tb_transpose_rd_fsm_mh;
  localparam int TIN  = 64;
  localparam int TOUT = 16;
  localparam int R    = TIN / TOUT;

  typedef struct packed {
    logic [5:0] addr;
    logic [6:0] amax;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] pixel_in = 12'd0;
  logic [11:0] pixel_out = 12'd0;
  logic [3:0]  head_num = 4'd0;
  logic        busy, done, rd_vld, rd_last;
  logic        rd_rdy = 1'b0;
  logic        credit_vld = 1'b0;
  logic [5:0]  rd_addr;
  logic [6:0]  rd_addr_max;
`ifdef TRANSPOSE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  beat_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int beat_total = 0;
  int vld_total = 0;
  int done_total = 0;
  int done_cyc = -1;
  int last_beat_cyc = -1;
  int last_max = -1;
  bit fire_seen = 1'b0;
  int rdy_mode = 0;      // 0: rd_rdy = rdy_fix, 1: random
  bit rdy_fix = 1'b0;
  int credit_mode = 0;   // 0: none (pulses only), 1: echo beats, 2: always
  int pulse_cnt = 0;

  transpose_rd_fsm_mh #(
    .TIN(TIN), .TOUT(TOUT), .PIX_W(12), .HEAD_W(4), .CREDIT_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_in(pixel_in), .pixel_out(pixel_out), .head_num(head_num),
    .busy(busy), .done(done), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .rd_addr(rd_addr), .rd_addr_max(rd_addr_max), .rd_last(rd_last),
    .credit_vld(credit_vld)
`ifdef TRANSPOSE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic void push_job(input int pi, input int po, input int hn);
    int nci, nco, rem, len;
    bit lt;
    beat_t b;
    nci = (po + TIN - 1) / TIN;
    nco = (pi + TOUT - 1) / TOUT;
    rem = pi - (nco - 1) * TOUT;
    for (int h = 0; h < hn; h++)
      for (int co = 0; co < nco; co++)
        for (int ci = 0; ci < nci; ci++) begin
          lt  = (co == nco - 1);
          len = lt ? rem : TOUT;
          for (int row = 0; row < len; row++)
            for (int bi = 0; bi < R; bi++) begin
              b.addr = 6'(row * R + bi);
              b.amax = 7'(lt ? rem * R : TIN);
              b.last = (h == hn - 1) && (ci == nci - 1) && lt &&
                       (row == len - 1) && (bi == R - 1);
              sb.push_back(b);
            end
        end
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic driver();
    int sent = 0;
    forever begin
      @(posedge clk);
      #1;
      rd_rdy = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_fix;
      if (pulse_cnt > sent) begin
        credit_vld = 1'b1;
        sent++;
      end else begin
        credit_vld = (credit_mode == 2) || ((credit_mode == 1) && fire_seen);
      end
    end
  endtask

  task automatic monitor();
    bit    hold_chk = 1'b0;
    beat_t held, got, exp;
    forever begin
      @(negedge clk);
      got = {rd_addr, rd_addr_max, rd_last};
      fire_seen = (rd_vld === 1'b1) && (rd_rdy === 1'b1);
      if (rd_vld === 1'b1) vld_total++;
      if (done === 1'b1) begin
        done_total++;
        done_cyc = cyc;
      end
      if (hold_chk && (rd_vld === 1'b1) && !rst) begin
        tests_run++;
        if (got !== held) begin
          tests_failed++;
          $display("FAIL hold_stable: got addr=%0d max=%0d last=%0d expected addr=%0d max=%0d last=%0d",
                   got.addr, got.amax, got.last, held.addr, held.amax, held.last);
        end
      end
      if (fire_seen) begin
        beat_total++;
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_beat: got addr=%0d with empty scoreboard", got.addr);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            tests_failed++;
            $display("FAIL beat: got addr=%0d max=%0d last=%0d expected addr=%0d max=%0d last=%0d",
                     got.addr, got.amax, got.last, exp.addr, exp.amax, exp.last);
          end
        end
        if (rd_last === 1'b1) begin
          last_beat_cyc = cyc;
          last_max = int'(rd_addr_max);
        end
      end
      hold_chk = (rd_vld === 1'b1) && (rd_rdy === 1'b0);
      held = got;
    end
  endtask

  task automatic do_start(input int pi, input int po, input int hn, output int scyc);
    pixel_in  = 12'(pi);
    pixel_out = 12'(po);
    head_num  = 4'(hn);
    start     = 1'b1;
    scyc      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_total > base) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, rd_vld, rd_last} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, rd_vld, rd_last});
    end
    tests_run++;
    if ({rd_addr, rd_addr_max} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_addr: got addr=%0d max=%0d expected 0 0", rd_addr, rd_addr_max);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_full_job(input string name, input int pi, input int po, input int hn,
                              input int nbeats, input int budget);
    int b0, d0, scyc;
    bit to;
    b0 = beat_total;
    d0 = done_total;
    push_job(pi, po, hn);
    do_start(pi, po, hn, scyc);
    wait_done(d0, budget, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    tests_run++;
    if (beat_total - b0 != nbeats) begin
      tests_failed++;
      $display("FAIL %s_beats: got %0d expected %0d", name, beat_total - b0, nbeats);
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_leftover: got %0d expected 0", name, sb.size());
    end
    tests_run++;
    if (done_cyc != last_beat_cyc + 1) begin
      tests_failed++;
      $display("FAIL %s_done_latency: got cycle %0d expected %0d", name, done_cyc, last_beat_cyc + 1);
    end
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s_idle: got busy,done=%b expected 00", name, {busy, done});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (done_total - d0 != 1) begin
      tests_failed++;
      $display("FAIL %s_done_count: got %0d expected 1", name, done_total - d0);
    end
    sb.delete();
  endtask

  task automatic test_multi_head();
    credit_mode = 1;
    rdy_mode = 0;
    rdy_fix = 1'b1;
    run_full_job("multi_head", 20, 64, 2, 160, 400);
  endtask

  task automatic test_backpressure();
    credit_mode = 1;
    rdy_mode = 1;
    run_full_job("backpressure", 20, 64, 2, 160, 2000);
    rdy_mode = 0;
  endtask

  task automatic test_large_job();
    credit_mode = 2;
    rdy_fix = 1'b1;
    run_full_job("large", 197, 192, 1, 2364, 3000);
    tests_run++;
    if (last_max != 20) begin
      tests_failed++;
      $display("FAIL large_last_max: got %0d expected 20", last_max);
    end
  endtask

  task automatic test_credit_starvation();
    int b0, scyc;
    credit_mode = 0;
    rdy_fix = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    push_job(20, 64, 1);
    b0 = beat_total;
    do_start(20, 64, 1, scyc);
    repeat (13) @(posedge clk);
    #1;
    tests_run++;
    if (beat_total - b0 != 3) begin
      tests_failed++;
      $display("FAIL starve_beats: got %0d expected 3", beat_total - b0);
    end
    tests_run++;
    if (rd_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_vld: got %b expected 0", rd_vld);
    end
`ifdef TRANSPOSE_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== 32'd10) begin
      tests_failed++;
      $display("FAIL stall_cnt_10: got %0d expected 10", stall_cnt);
    end
`endif
    pulse_cnt++;
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (beat_total - b0 != 4) begin
      tests_failed++;
      $display("FAIL credit_pulse_beats: got %0d expected 4", beat_total - b0);
    end
  endtask

  task automatic test_start_while_busy();
    int b0, scyc;
`ifdef TRANSPOSE_STALL_CNT_EN
    logic [31:0] s0;
    s0 = stall_cnt;
`endif
    b0 = beat_total;
    do_start(5, 5, 1, scyc);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignore_start_busy: got %b expected 1", busy);
    end
`ifdef TRANSPOSE_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== s0 + 32'd1) begin
      tests_failed++;
      $display("FAIL ignore_start_stall: got %0d expected %0d", stall_cnt, s0 + 32'd1);
    end
`endif
    tests_run++;
    if (beat_total != b0) begin
      tests_failed++;
      $display("FAIL ignore_start_beats: got %0d expected %0d", beat_total, b0);
    end
  endtask

  task automatic test_reset_abort();
    int d0, b0, scyc;
    bit to;
    d0 = done_total;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if ({busy, rd_vld, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy,vld,done=%b expected 000", {busy, rd_vld, done});
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done_total != d0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", done_total - d0);
    end
    sb.delete();
    // Credits were exhausted before reset; exactly CREDIT_MAX beats now.
    push_job(20, 64, 1);
    b0 = beat_total;
    do_start(20, 64, 1, scyc);
    repeat (13) @(posedge clk);
    #1;
    tests_run++;
    if (beat_total - b0 != 3) begin
      tests_failed++;
      $display("FAIL abort_credit_reset: got %0d beats expected 3", beat_total - b0);
    end
    credit_mode = 2;
    wait_done(d0, 300, to);
    tests_run++;
    if (to || (sb.size() != 0) || (beat_total - b0 != 80)) begin
      tests_failed++;
      $display("FAIL abort_resume: got timeout=%0d left=%0d beats=%0d expected 0 0 80",
               to, sb.size(), beat_total - b0);
    end
  endtask

  task automatic test_zero_head();
    int d0, v0, scyc;
    bit to;
    d0 = done_total;
    v0 = vld_total;
    do_start(20, 64, 0, scyc);
`ifdef TRANSPOSE_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL stall_cnt_clear: got %0d expected 0", stall_cnt);
    end
`endif
    wait_done(d0, 10, to);
    tests_run++;
    if (to || (done_cyc != scyc + 1)) begin
      tests_failed++;
      $display("FAIL zero_head_done: got timeout=%0d cycle=%0d expected 0 %0d", to, done_cyc, scyc + 1);
    end
    tests_run++;
    if ((vld_total != v0) || (busy !== 1'b0)) begin
      tests_failed++;
      $display("FAIL zero_head_vld: got vld_cycles=%0d busy=%b expected 0 0", vld_total - v0, busy);
    end
  endtask

  initial begin
    fork
      cycle_counter();
      driver();
      monitor();
    join_none
    test_reset();
    test_multi_head();
    test_backpressure();
    test_large_job();
    test_credit_starvation();
    test_start_while_busy();
    test_reset_abort();
    test_zero_head();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
